// File: rtl/axil_read_link_pkg.sv
// Shared types and constants for the AXI4-Lite read link.
// Holds response codes, master FSM encoding and register contents.
package axil_read_link_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [2:0] PROT_NONE = 3'b000;
    localparam int REG_COUNT = 4;
    localparam logic [31:0] REG_STEP = 32'h1111_1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } mst_state_e;

    function automatic logic [31:0] reg_init(input int k);
        reg_init = REG_STEP * 32'(k + 1);
    endfunction

endpackage

// File: rtl/axil_read_link_master.sv
// AXI4-Lite read master: issues one read of a fixed address per reset.
// Captures the returned word and then parks in DONE.
module master_file
    import axil_read_link_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int address = 12
) (
    input  logic                          m_aclk,
    input  logic                          m_aresetn,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]                    m_arprot,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_rdata,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] read_data,
    output logic                          read_done
);

    mst_state_e state;

    assign m_araddr = C_M_AXI_ADDR_WIDTH'(address);
    assign m_arprot = PROT_NONE;

    always_ff @(posedge m_aclk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            state     <= ST_IDLE;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            read_data <= '0;
            read_done <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state     <= ST_ADDR;
                    m_arvalid <= 1'b1;
                end
                ST_ADDR: begin
                    if (m_arvalid && m_arready) begin
                        state     <= ST_DATA;
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (m_rvalid && m_rready) begin
                        state     <= ST_DONE;
                        read_data <= m_rdata;
                        m_rready  <= 1'b0;
                        read_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    read_done <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/axil_read_link_slave.sv
// AXI4-Lite read slave over a 4-entry constant register file.
// Accepts one address at a time and always answers OKAY.
module slave_file
    import axil_read_link_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4
) (
    input  logic                          s_aclk,
    input  logic                          s_aresetn,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic [2:0]                    s_arprot,
    input  logic                          s_arvalid,
    output logic                          s_arready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rvalid,
    input  logic                          s_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] data,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rdata_out
);

    logic [C_M_AXI_DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [1:0] sel;
    logic       unused_bits;

    always_comb begin
        for (int k = 0; k < REG_COUNT; k++) begin
            regs[k] = C_M_AXI_DATA_WIDTH'(reg_init(k));
        end
    end

    // Word-aligned decode; byte offset and protection are ignored.
    assign sel         = s_araddr[3:2];
    assign unused_bits = ^{s_araddr, s_arprot};
    assign s_rresp     = RESP_OKAY;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            data      <= '0;
            rdata_out <= '0;
        end else begin
            s_arready <= s_arvalid && !s_arready && !s_rvalid;
            if (s_arvalid && s_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= regs[sel];
                data     <= regs[sel];
            end else if (s_rvalid && s_rready) begin
                s_rvalid  <= 1'b0;
                rdata_out <= s_rdata;
            end
        end
    end

endmodule

// File: rtl/axil_read_link.sv
// Top: connects the read master to the register-file slave.
// Exposes both sides of the AR/R channels for observation.
module axil_read_link
    import axil_read_link_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int address = 12
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] araddr,
    output logic                          arvalid,
    output logic                          arready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                    rresp,
    output logic                          rvalid,
    output logic                          rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] read_data,
    output logic                          read_done,
    output logic [C_M_AXI_DATA_WIDTH-1:0] data,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rdata_out
);

    logic [2:0] arprot;

    master_file #(
        .C_M_AXI_DATA_WIDTH(C_M_AXI_DATA_WIDTH),
        .C_M_AXI_ADDR_WIDTH(C_M_AXI_ADDR_WIDTH),
        .address           (address)
    ) u_master (
        .m_aclk    (aclk),
        .m_aresetn (aresetn),
        .m_araddr  (araddr),
        .m_arprot  (arprot),
        .m_arvalid (arvalid),
        .m_arready (arready),
        .m_rdata   (rdata),
        .m_rvalid  (rvalid),
        .m_rready  (rready),
        .read_data (read_data),
        .read_done (read_done)
    );

    slave_file #(
        .C_M_AXI_DATA_WIDTH(C_M_AXI_DATA_WIDTH),
        .C_M_AXI_ADDR_WIDTH(C_M_AXI_ADDR_WIDTH)
    ) u_slave (
        .s_aclk    (aclk),
        .s_aresetn (aresetn),
        .s_araddr  (araddr),
        .s_arprot  (arprot),
        .s_arvalid (arvalid),
        .s_arready (arready),
        .s_rdata   (rdata),
        .s_rresp   (rresp),
        .s_rvalid  (rvalid),
        .s_rready  (rready),
        .data      (data),
        .rdata_out (rdata_out)
    );

endmodule

// File: tb/tb_axil_read_link.sv
// Bench for axil_read_link: edge table, abort sequence, random resets.
// Expected values come from a cycle-timeline model of the read.
module tb_axil_read_link;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] araddr;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid, rready;
    logic [DW-1:0] read_data;
    logic          read_done;
    logic [DW-1:0] data, rdata_out;

    logic [AW-1:0] a0_araddr, a5_araddr;
    logic          a0_arv, a0_arr, a0_rv, a0_rr, a0_done;
    logic          a5_arv, a5_arr, a5_rv, a5_rr, a5_done;
    logic [DW-1:0] a0_rdata, a0_rd, a0_data, a0_rout;
    logic [DW-1:0] a5_rdata, a5_rd, a5_data, a5_rout;
    logic [1:0]    a0_rresp, a5_rresp;

    int n_cmp = 0;
    int n_err = 0;

    always #10 aclk = ~aclk;

    axil_read_link #(.address(12)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .araddr(araddr), .arvalid(arvalid),
        .arready(arready), .rdata(rdata),
        .rresp(rresp), .rvalid(rvalid),
        .rready(rready), .read_data(read_data),
        .read_done(read_done), .data(data),
        .rdata_out(rdata_out)
    );

    axil_read_link #(.address(0)) dut_a0 (
        .aclk(aclk), .aresetn(aresetn),
        .araddr(a0_araddr), .arvalid(a0_arv),
        .arready(a0_arr), .rdata(a0_rdata),
        .rresp(a0_rresp), .rvalid(a0_rv),
        .rready(a0_rr), .read_data(a0_rd),
        .read_done(a0_done), .data(a0_data),
        .rdata_out(a0_rout)
    );

    axil_read_link #(.address(5)) dut_a5 (
        .aclk(aclk), .aresetn(aresetn),
        .araddr(a5_araddr), .arvalid(a5_arv),
        .arready(a5_arr), .rdata(a5_rdata),
        .rresp(a5_rresp), .rvalid(a5_rv),
        .rready(a5_rr), .read_data(a5_rd),
        .read_done(a5_done), .data(a5_data),
        .rdata_out(a5_rout)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_val(input int addr);
        return 32'h1111_1111 * 32'(((addr / 4) % 4) + 1);
    endfunction

    // Expected view n edges after reset release (n=0: none yet).
    typedef struct packed {
        logic        arv, arr, rv, rr, done;
        logic [31:0] rdat, rd, dat, rout;
    } exp_t;

    function automatic exp_t model(input int n, input logic [31:0] v);
        exp_t e;
        e.arv  = (n == 1) || (n == 2);
        e.arr  = (n == 2);
        e.rv   = (n == 3);
        e.rr   = (n == 3);
        e.done = (n >= 4);
        e.rdat = (n >= 3) ? v : 32'h0;
        e.dat  = (n >= 3) ? v : 32'h0;
        e.rd   = (n >= 4) ? v : 32'h0;
        e.rout = (n >= 4) ? v : 32'h0;
        return e;
    endfunction

    task automatic check_model(input string tag, input int n);
        exp_t e;
        e = model(n, reg_val(12));
        chk({tag, ".arvalid"}, 32'(arvalid), 32'(e.arv));
        chk({tag, ".arready"}, 32'(arready), 32'(e.arr));
        chk({tag, ".rvalid"}, 32'(rvalid), 32'(e.rv));
        chk({tag, ".rready"}, 32'(rready), 32'(e.rr));
        chk({tag, ".read_done"}, 32'(read_done), 32'(e.done));
        chk({tag, ".rdata"}, rdata, e.rdat);
        chk({tag, ".read_data"}, read_data, e.rd);
        chk({tag, ".data"}, data, e.dat);
        chk({tag, ".rdata_out"}, rdata_out, e.rout);
        chk({tag, ".rresp"}, 32'(rresp), 32'h0);
        chk({tag, ".araddr"}, 32'(araddr), 32'd12);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic release_rst();
        @(negedge aclk);
        #1 aresetn = 1'b1;
    endtask

    // Protocol monitor, sampled on the falling edge.
    logic        p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0;
    logic        p_rst = 0;
    logic [31:0] p_rdata = 0;
    int          outstanding = 0;

    always @(negedge aclk) begin
        if (aresetn && p_rst) begin
            if (p_arv && !p_arr)
                chk("arvalid_hold", 32'(arvalid), 32'h1);
            if (p_rv && !p_rr && rvalid)
                chk("rdata_stable", rdata, p_rdata);
        end
        if (!aresetn) begin
            outstanding = 0;
        end else begin
            if (arvalid && arready) outstanding++;
            if (rvalid && rready) outstanding--;
            chk("outstanding", 32'(outstanding <= 1), 32'h1);
        end
        p_arv   = arvalid;
        p_arr   = arready;
        p_rv    = rvalid;
        p_rr    = rready;
        p_rdata = rdata;
        p_rst   = aresetn;
    end

    typedef struct {
        int          edge_n;
        logic        arv, arr, rv, rr, done;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{0, 0, 0, 0, 0, 0, 32'h0};
        tbl[1] = '{1, 1, 0, 0, 0, 0, 32'h0};
        tbl[2] = '{2, 1, 1, 0, 0, 0, 32'h0};
        tbl[3] = '{3, 0, 0, 1, 1, 0, 32'h0};
        tbl[4] = '{4, 0, 0, 0, 0, 1, 32'h4444_4444};
        tbl[5] = '{5, 0, 0, 0, 0, 1, 32'h4444_4444};
        tbl[6] = '{6, 0, 0, 0, 0, 1, 32'h4444_4444};

        // Long reset: everything held at zero.
        #1;
        for (int c = 0; c < 10; c++) begin
            check_model("in_reset", 0);
            step();
        end

        // Edge-by-edge table after release.
        release_rst();
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].edge_n > 0) step();
            chk($sformatf("tbl%0d.arvalid", i),
                32'(arvalid), 32'(tbl[i].arv));
            chk($sformatf("tbl%0d.arready", i),
                32'(arready), 32'(tbl[i].arr));
            chk($sformatf("tbl%0d.rvalid", i),
                32'(rvalid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d.rready", i),
                32'(rready), 32'(tbl[i].rr));
            chk($sformatf("tbl%0d.read_done", i),
                32'(read_done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d.read_data", i),
                read_data, tbl[i].rd);
        end
        chk("addr0.read_data", a0_rd, 32'h1111_1111);
        chk("addr5.read_data", a5_rd, 32'h2222_2222);
        chk("addr0.done", 32'(a0_done), 32'h1);
        chk("addr5.done", 32'(a5_done), 32'h1);

        // Terminal DONE: no further requests.
        for (int c = 0; c < 20; c++) begin
            step();
            chk("done.arvalid", 32'(arvalid), 32'h0);
        end
        chk("done.data", data, 32'h4444_4444);
        chk("done.rdata_out", rdata_out, 32'h4444_4444);
        chk("done.read_data", read_data, 32'h4444_4444);

        // Abort while rvalid is high, then a clean retry.
        aresetn = 1'b0;
        step();
        release_rst();
        for (int n = 1; n <= 3; n++) begin
            step();
            check_model("pre_abort", n);
        end
        #5 aresetn = 1'b0;
        #1 check_model("abort", 0);
        step();
        check_model("abort_hold", 0);
        release_rst();
        for (int n = 1; n <= 4; n++) begin
            step();
            check_model("retry", n);
        end

        // Random reset pulses at random points of the read.
        for (int it = 0; it < 40; it++) begin
            int run;
            int dly;
            int hold;
            run  = $urandom_range(0, 7);
            dly  = $urandom_range(1, 17);
            hold = $urandom_range(1, 3);
            aresetn = 1'b0;
            step();
            release_rst();
            check_model("rnd", 0);
            for (int n = 1; n <= run; n++) begin
                step();
                check_model("rnd", n);
            end
            #(dly) aresetn = 1'b0;
            #1 check_model("rnd_abort", 0);
            for (int c = 0; c < hold; c++) begin
                step();
                check_model("rnd_hold", 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
